interrupt_controller_multi: RTL

Parametrised interrupt front-end for the 6502-style core. It replaces the single-IRQ injector with NUM_IRQ maskable request channels, each configurable as level or edge. It keeps edge-detected NMI and post-reset vector injection. A single FSM arbitrates the three sources, raises pending_interrupt toward the control logic, and reports the serviced source and IRQ channel index until the handler finishes.

---
 rtl/interrupt_controller_multi_if.sv | 37 +++
 rtl/interrupt_controller_multi.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller_multi_if.sv
// Bus between the CPU control logic and the interrupt front-end.
// master: the core / testbench side (drives requests, mask, flags, ack).
// slave : the interrupt controller (drives pending/generated/running, irq_id,
//         irq_pending).
interface interrupt_controller_multi_if #(
    parameter int NUM_IRQ = 4,
    parameter int ID_W    = 2
);
    logic               enableFFs;
    logic               nmi_in;
    logic [NUM_IRQ-1:0] irq_in;
    logic [NUM_IRQ-1:0] irq_mask;
    logic               i_flag;
    logic               interrupt_started;

    logic               pending_interrupt;
    logic               reset_detected;
    logic               nmi_generated;
    logic               irq_generated;
    logic               reset_running;
    logic               nmi_running;
    logic               irq_running;
    logic [ID_W-1:0]    irq_id;
    logic [NUM_IRQ-1:0] irq_pending;

    modport master (
        output enableFFs, nmi_in, irq_in, irq_mask, i_flag, interrupt_started,
        input  pending_interrupt, reset_detected, nmi_generated, irq_generated,
               reset_running, nmi_running, irq_running, irq_id, irq_pending
    );

    modport slave (
        input  enableFFs, nmi_in, irq_in, irq_mask, i_flag, interrupt_started,
        output pending_interrupt, reset_detected, nmi_generated, irq_generated,
               reset_running, nmi_running, irq_running, irq_id, irq_pending
    );
endinterface

// File: rtl/interrupt_controller_multi.sv
// Multi-channel interrupt front-end for the 6502-style core.
// Arbitrates post-reset vector injection, edge-detected NMI and NUM_IRQ
// maskable IRQ channels (each level or rising-edge latched), and reports the
// serviced source and IRQ channel until the handler returns.
// Ports:
//   clk, nrst  - clock, asynchronous active-low reset
//   bus        - interrupt_controller_multi_if.slave: enableFFs, nmi_in,
//                irq_in, irq_mask, i_flag, interrupt_started in;
//                pending_interrupt, *_detected/*_generated, *_running,
//                irq_id, irq_pending out

// One request line: synchronizer, rising-edge detector and a sticky latch.
// Clocked every cycle so edges are never lost while the core is stalled.
// req is the latch in edge mode, the synchronized level otherwise.
module interrupt_controller_multi_chan #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE        = 1'b0
) (
    input  logic clk,
    input  logic nrst,
    input  logic line_in,
    input  logic clr,
    output logic req
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   latch_q, latch_d;
    logic                   lvl;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], line_in};
        lvl     = sync_q[SYNC_STAGES-1];
        prev_d  = lvl;
        // set beats clear when an edge lands on the acceptance cycle
        latch_d = (lvl & ~prev_q) | (latch_q & ~clr);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            latch_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            latch_q <= latch_d;
        end
    end

    assign req = EDGE ? latch_q : lvl;
endmodule

module interrupt_controller_multi #(
    parameter int                 NUM_IRQ     = 4,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [NUM_IRQ-1:0] EDGE_MODE   = '0,
    parameter int                 ID_W        = 2
) (
    input logic                        clk,
    input logic                        nrst,
    interrupt_controller_multi_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_RUNNING} state_e;
    typedef enum logic [1:0] {SVC_RESET, SVC_NMI, SVC_IRQ} svc_e;

    state_e             state_q, state_d;
    svc_e               svc_q, svc_d;
    logic [ID_W-1:0]    id_q, id_d;

    logic               accept;
    logic               nmi_clr;
    logic               nmi_latched;
    logic [NUM_IRQ-1:0] req;
    logic [NUM_IRQ-1:0] irq_clr;
    logic [NUM_IRQ-1:0] irq_pending;
    logic               irq_any;
    logic [ID_W-1:0]    low_id;

    // acceptance of the pending request retires its source latch
    assign accept  = bus.enableFFs && (state_q == ST_PENDING) && bus.interrupt_started;
    assign nmi_clr = accept && (svc_q == SVC_NMI);

    interrupt_controller_multi_chan #(
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE        (1'b1)
    ) u_nmi (
        .clk     (clk),
        .nrst    (nrst),
        .line_in (bus.nmi_in),
        .clr     (nmi_clr),
        .req     (nmi_latched)
    );

    for (genvar k = 0; k < NUM_IRQ; k++) begin : g_ch
        assign irq_clr[k] = accept && (svc_q == SVC_IRQ) && (id_q == ID_W'(k));

        interrupt_controller_multi_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE        (EDGE_MODE[k])
        ) u_ch (
            .clk     (clk),
            .nrst    (nrst),
            .line_in (bus.irq_in[k]),
            .clr     (irq_clr[k]),
            .req     (req[k])
        );
    end

    assign irq_pending = req & bus.irq_mask;
    assign irq_any     = |irq_pending;

    // lowest set index wins: scan downward so the last hit is the lowest
    always_comb begin
        low_id = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (irq_pending[k]) low_id = ID_W'(k);
        end
    end

    always_comb begin
        state_d = state_q;
        svc_d   = svc_q;
        id_d    = id_q;
        if (bus.enableFFs) begin
            case (state_q)
                ST_IDLE: begin
                    if (nmi_latched) begin
                        state_d = ST_PENDING;
                        svc_d   = SVC_NMI;
                    end else if (irq_any && !bus.i_flag) begin
                        state_d = ST_PENDING;
                        svc_d   = SVC_IRQ;
                        id_d    = low_id;
                    end
                end
                ST_PENDING: begin
                    // committed: only the ack or an NMI hijack moves us
                    if (bus.interrupt_started) begin
                        state_d = ST_RUNNING;
                    end else if (svc_q == SVC_IRQ && nmi_latched) begin
                        svc_d = SVC_NMI;
                    end
                end
                ST_RUNNING: begin
                    if (svc_q == SVC_IRQ && nmi_latched) begin
                        state_d = ST_PENDING;
                        svc_d   = SVC_NMI;
                    end else if (!bus.i_flag) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_PENDING;
            svc_q   <= SVC_RESET;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            svc_q   <= svc_d;
            id_q    <= id_d;
        end
    end

    assign bus.pending_interrupt = (state_q == ST_PENDING);
    assign bus.reset_detected    = (state_q == ST_PENDING) && (svc_q == SVC_RESET);
    assign bus.nmi_generated     = (state_q == ST_PENDING) && (svc_q == SVC_NMI);
    assign bus.irq_generated     = (state_q == ST_PENDING) && (svc_q == SVC_IRQ);
    assign bus.reset_running     = (state_q == ST_RUNNING) && (svc_q == SVC_RESET);
    assign bus.nmi_running       = (state_q == ST_RUNNING) && (svc_q == SVC_NMI);
    assign bus.irq_running       = (state_q == ST_RUNNING) && (svc_q == SVC_IRQ);
    assign bus.irq_id            = id_q;
    assign bus.irq_pending       = irq_pending;
endmodule
